// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator: sums fixed-length frames of multiplier products with saturation, valid/ready on both sides.
// Optional macro ACC_SIGNED_EN selects two's-complement products and a signed accumulator.  Rev 1.0
`default_nettype none

module mult_product_accumulator #(
   parameter int PROD_W    = 8,
   parameter int ACC_W     = 10,
   parameter int FRAME_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              clear,
   input  logic [PROD_W-1:0] p_in,
   input  logic              p_valid,
   output logic              p_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic              overflow,
   output logic              busy
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   count;
   logic               ovf;

   logic [ACC_W:0]     ext;
   logic [ACC_W:0]     sum;
   logic               sat_now;
   logic [ACC_W-1:0]   clamp;
   logic [ACC_W-1:0]   sat_sum;
   logic               accept;

`ifdef ACC_SIGNED_EN
   assign ext     = {{(ACC_W + 1 - PROD_W){p_in[PROD_W-1]}}, p_in};
   assign sum     = {acc[ACC_W-1], acc} + ext;
   // Disagreeing top two bits of the widened sum mean the result left the signed range.
   assign sat_now = sum[ACC_W] ^ sum[ACC_W-1];
   assign clamp   = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
   assign ext     = {{(ACC_W + 1 - PROD_W){1'b0}}, p_in};
   assign sum     = {1'b0, acc} + ext;
   assign sat_now = sum[ACC_W];
   assign clamp   = {ACC_W{1'b1}};
`endif

   assign sat_sum   = sat_now ? clamp : sum[ACC_W-1:0];
   assign p_ready   = ena & ~rst & (state != HOLD);
   assign accept    = p_valid & p_ready;
   assign acc_out   = acc;
   assign acc_valid = (state == HOLD);
   assign busy      = (state == ACCUM);
   assign overflow  = ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (ena) begin
         // clear wins over everything, including a pending output handshake.
         if (clear) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     acc   <= ext[ACC_W-1:0];
                     count <= CNT_W'(1);
                     state <= (FRAME_LEN == 1) ? HOLD : ACCUM;
                  end
               end
               ACCUM: begin
                  if (accept) begin
                     acc   <= sat_sum;
                     count <= count + CNT_W'(1);
                     if (sat_now) begin
                        ovf <= 1'b1;
                     end
                     if (count == LAST_CNT) begin
                        state <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (acc_ready) begin
                     state <= IDLE;
                     acc   <= '0;
                     count <= '0;
                     ovf   <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mult_product_accumulator.sv
// Directed bench for mult_product_accumulator: frames, back-pressure, saturation, clear, async reset, ena freeze.
`default_nettype none

module tb_mult_product_accumulator;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       clear;
   logic [7:0] p_in;
   logic       p_valid;
   logic       p_ready;
   logic [9:0] acc_out;
   logic       acc_valid;
   logic       acc_ready;
   logic       overflow;
   logic       busy;

   int checks = 0;
   int errors = 0;

   mult_product_accumulator #(
      .PROD_W   (8),
      .ACC_W    (10),
      .FRAME_LEN(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .clear    (clear),
      .p_in     (p_in),
      .p_valid  (p_valid),
      .p_ready  (p_ready),
      .acc_out  (acc_out),
      .acc_valid(acc_valid),
      .acc_ready(acc_ready),
      .overflow (overflow),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      p_in    = v;
      p_valid = 1'b1;
      tick();
      p_valid = 1'b0;
   endtask

   task automatic drain();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; clear = 1'b0;
      p_in = '0; p_valid = 1'b0; acc_ready = 1'b0;
      #2;
      chk("rst_acc_out",   32'(acc_out), 0);
      chk("rst_acc_valid", 32'(acc_valid), 0);
      chk("rst_p_ready",   32'(p_ready), 0);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_overflow",  32'(overflow), 0);
      #10 rst = 1'b0;
      tick();
      chk("idle_p_ready", 32'(p_ready), 1);

      // Frame 1..8, then hold under back-pressure.
      for (int i = 1; i <= 8; i++) begin
         push(8'(i));
         if (i == 1) chk("busy_after_first", 32'(busy), 1);
         if (i == 7) chk("valid_before_last", 32'(acc_valid), 0);
      end
      chk("f1_acc_valid", 32'(acc_valid), 1);
      chk("f1_acc_out",   32'(acc_out), 36);
      chk("f1_overflow",  32'(overflow), 0);
      chk("f1_p_ready",   32'(p_ready), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_acc_out",   32'(acc_out), 36);
         chk("hold_acc_valid", 32'(acc_valid), 1);
      end
      drain();
      chk("post_hs_valid",   32'(acc_valid), 0);
      chk("post_hs_acc_out", 32'(acc_out), 0);
      chk("post_hs_p_ready", 32'(p_ready), 1);
      push(8'd7);
      chk("next_first_acc", 32'(acc_out), 7);
      chk("next_first_busy", 32'(busy), 1);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear_idle_acc", 32'(acc_out), 0);

      // Unsigned saturation: 8 x 200 = 1600.
      for (int i = 0; i < 8; i++) push(8'd200);
      chk("sat_acc_out",  32'(acc_out), 1023);
      chk("sat_overflow", 32'(overflow), 1);
      chk("sat_valid",    32'(acc_valid), 1);
      drain();
      chk("sat_ovf_clr",  32'(overflow), 0);
      chk("sat_acc_clr",  32'(acc_out), 0);

      // Clear aborts a partial frame; the product presented alongside it is dropped.
      for (int i = 0; i < 3; i++) push(8'd50);
      chk("partial_acc", 32'(acc_out), 150);
      clear = 1'b1; p_in = 8'd9; p_valid = 1'b1;
      #1;
      chk("clear_p_ready", 32'(p_ready), 1);
      tick();
      clear = 1'b0; p_valid = 1'b0;
      chk("clr_acc_out", 32'(acc_out), 0);
      chk("clr_busy",    32'(busy), 0);
      chk("clr_valid",   32'(acc_valid), 0);
      for (int i = 0; i < 8; i++) push(8'd1);
      chk("after_clr_acc",   32'(acc_out), 8);
      chk("after_clr_valid", 32'(acc_valid), 1);

      // ena low freezes the held frame even with acc_ready high.
      ena = 1'b0; acc_ready = 1'b1;
      #1;
      chk("ena0_p_ready", 32'(p_ready), 0);
      tick(); tick();
      chk("ena0_valid", 32'(acc_valid), 1);
      chk("ena0_acc",   32'(acc_out), 8);
      ena = 1'b1;
      tick();
      acc_ready = 1'b0;
      chk("ena1_hs_valid", 32'(acc_valid), 0);

      // Clear beats the HOLD handshake.
      for (int i = 0; i < 8; i++) push(8'd3);
      chk("f3_acc", 32'(acc_out), 24);
      clear = 1'b1; acc_ready = 1'b1;
      tick();
      clear = 1'b0; acc_ready = 1'b0;
      chk("clr_hold_valid", 32'(acc_valid), 0);
      chk("clr_hold_acc",   32'(acc_out), 0);

      // Asynchronous reset between clock edges after four products.
      for (int i = 0; i < 4; i++) push(8'd5);
      chk("pre_rst_acc", 32'(acc_out), 20);
      #2 rst = 1'b1;
      #1;
      chk("arst_acc_out", 32'(acc_out), 0);
      chk("arst_valid",   32'(acc_valid), 0);
      chk("arst_p_ready", 32'(p_ready), 0);
      chk("arst_busy",    32'(busy), 0);
      tick();
      #2 rst = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) push(8'd2);
      chk("post_rst_acc",   32'(acc_out), 16);
      chk("post_rst_valid", 32'(acc_valid), 1);
      drain();

      // 8 x 0x80: -1024 clamps to -512 when signed, 1024 clamps to 1023 otherwise.
      for (int i = 0; i < 8; i++) push(8'h80);
`ifdef ACC_SIGNED_EN
      chk("x80_acc_out", 32'(acc_out), 32'h200);
`else
      chk("x80_acc_out", 32'(acc_out), 1023);
`endif
      chk("x80_overflow", 32'(overflow), 1);
      drain();
      chk("x80_ovf_clr", 32'(overflow), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Stage directly downstream of the array multiplier: consumes its 8-bit product stream and sums fixed-length frames of products into one accumulated result.
- Valid/ready handshake on both sides. Saturating arithmetic with a sticky overflow flag. A frame result is held until downstream accepts it.
- Forms the accumulate half of the multiply-accumulate datapath on the Tiny Tapeout tile.

Parameters:
- PROD_W, 8: product width; matches the multiplier output p.
- ACC_W, 10: accumulator and result width; must be >= PROD_W.
- FRAME_LEN, 8: products summed per frame; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  clock-enable; when low, all internal state is frozen.
- clear  in  1  synchronous frame abort.
- p_in  in  PROD_W  product from the multiplier.
- p_valid  in  1  p_in is valid this cycle.
- p_ready  out  1  block can accept p_in.
- acc_out  out  ACC_W  frame result.
- acc_valid  out  1  acc_out holds a completed frame.
- acc_ready  in  1  downstream accepts acc_out.
- overflow  out  1  saturation occurred in the current or held frame.
- busy  out  1  one or more products accepted in the current frame.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, acc=0, count=0.
  - acc_out=0, acc_valid=0, overflow=0, busy=0, p_ready=0 while rst is high.
- States: IDLE, ACCUM, HOLD.
- p_ready = ena & !rst & (state != HOLD). Accept = p_valid & p_ready.
- IDLE:
  - On accept: acc <= p_in (zero-extended), count <= 1, go to ACCUM.
  - If FRAME_LEN=1: go directly to HOLD instead.
- ACCUM:
  - On accept: acc <= sat(acc + p_in), count <= count+1.
  - When the accepted product is the FRAME_LEN-th, go to HOLD.
- HOLD:
  - acc_valid=1; acc_out and overflow are stable.
  - On acc_valid & acc_ready & ena: acc <= 0, count <= 0, overflow <= 0, go to IDLE.
  - p_ready=0 in HOLD, so a new product can never be accepted in the same cycle as the output handshake.
  - The first product of the next frame is accepted the cycle after HOLD is left.
- Latency: acc_valid rises on the clock edge that accepts the last product of the frame, i.e. it is high in the cycle after that product was presented.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - If it exceeds 2^ACC_W-1, acc <= 2^ACC_W-1 and overflow <= 1.
  - overflow stays set until the frame is consumed, cleared, or reset.
- count: width clog2(FRAME_LEN+1). It never wraps; it returns to 0 only via the output handshake, clear, or rst.
- busy = (state==ACCUM).
- acc_out = acc in every state.
- clear (when ena=1):
  - In any state, forces acc=0, count=0, overflow=0, state=IDLE on the next edge. A product presented in that same cycle is discarded.
  - clear takes priority over the HOLD handshake, which is dropped.
  - p_ready stays as computed, so an upstream sender treats the discarded product as accepted.
- ena=0:
  - No state changes, including the HOLD handshake.
  - acc_valid is held if already high; p_ready=0.
- rst mid-frame: the partial frame is lost immediately, asynchronously.
- Never drop or double-count a product that completed a valid/ready handshake without clear asserted.

Optional Feature:
- Macro: ACC_SIGNED_EN.
- Defined:
  - p_in is treated as two's complement and sign-extended.
  - acc is signed.
  - Saturation clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1). overflow sets on either clamp.
- Undefined:
  - Unsigned behaviour as above; only upper-bound saturation is applied.

Test Plan:
- Reset, ena=1, present products 1..8 back-to-back with p_valid=1 -> acc_valid=1 the cycle after the 8th product, acc_out=36, overflow=0, p_ready=0 while held.
- Same frame with acc_ready low for 5 cycles, then high -> acc_out stable at 36 throughout; IDLE next cycle with acc_out=0; next product then accepted.
- Eight products of 200 each (sum 1600) -> acc_out=1023, overflow=1; both clear after the output handshake.
- Three products of 50, then clear=1 with p_valid=1 and p_in=9 -> IDLE, acc_out=0, busy=0; the next 8 products of 1 give acc_out=8.
- Assert rst asynchronously mid-frame (between clock edges) after 4 products -> acc_out=0, acc_valid=0 and p_ready=0 immediately; normal frame after release.
- With ACC_SIGNED_EN: eight products of 0x80 (-128), sum -1024 -> acc_out=-512 (0x200), overflow=1. Without it, the same stimulus (8 x 128 = 1024) -> acc_out=1023, overflow=1.
